// File: rtl/ysyx_210184_if_axi_rd_if.sv
// IF fetch port plus AXI4 AR/R read channel bundle.
// master: fetch responder side; slave: IF stage and crossbar side.
interface ysyx_210184_if_axi_rd_if;
  logic [63:0] inst_addr_i;
  logic        inst_req_i;
  logic [31:0] inst_o;
  logic        inst_ready_o;
  logic        inst_err_o;
  logic        ar_valid_o;
  logic        ar_ready_i;
  logic [63:0] ar_addr_o;
  logic [3:0]  ar_id_o;
  logic [7:0]  ar_len_o;
  logic [2:0]  ar_size_o;
  logic [1:0]  ar_burst_o;
  logic        r_valid_i;
  logic        r_ready_o;
  logic [63:0] r_data_i;
  logic [1:0]  r_resp_i;
  logic        r_last_i;
  logic [3:0]  r_id_i;

  modport master (
    input  inst_addr_i, inst_req_i,
    input  ar_ready_i,
    input  r_valid_i, r_data_i, r_resp_i,
    input  r_last_i, r_id_i,
    output inst_o, inst_ready_o, inst_err_o,
    output ar_valid_o, ar_addr_o, ar_id_o,
    output ar_len_o, ar_size_o, ar_burst_o,
    output r_ready_o
  );

  modport slave (
    output inst_addr_i, inst_req_i,
    output ar_ready_i,
    output r_valid_i, r_data_i, r_resp_i,
    output r_last_i, r_id_i,
    input  inst_o, inst_ready_o, inst_err_o,
    input  ar_valid_o, ar_addr_o, ar_id_o,
    input  ar_len_o, ar_size_o, ar_burst_o,
    input  r_ready_o
  );
endinterface

// File: rtl/ysyx_210184_if_axi_rd.sv
// Instruction fetch responder: one single-beat AXI4 read per fetch,
// result delivered as a one-cycle ready pulse if the PC still matches.
module ysyx_210184_if_axi_rd #(
  parameter logic [3:0]  AXI_ID   = 4'd0,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic clk,
  input  logic rst,
  ysyx_210184_if_axi_rd_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_RESP
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [63:0] addr_q;
  logic [31:0] inst_q;
  logic        err_q;
  logic        beat;
  logic        hit;
  logic        bad;
  logic        load_addr;
  logic        load_data;
  logic        pulse;

  assign beat = (state == S_R)
              & bus.r_valid_i
              & (bus.r_id_i == AXI_ID);
  assign hit  = bus.inst_req_i
              & (bus.inst_addr_i == addr_q);
  assign bad  = bus.r_resp_i != 2'b00;

  always_comb begin
    state_n   = state;
    load_addr = 1'b0;
    load_data = 1'b0;
    pulse     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.inst_req_i) begin
          load_addr = 1'b1;
          state_n   = S_AR;
        end
      end
      S_AR: begin
        if (bus.ar_ready_i) state_n = S_R;
      end
      S_R: begin
        if (beat && bus.r_last_i) begin
          load_data = 1'b1;
          state_n   = S_RESP;
        end
      end
      S_RESP: begin
        // A PC change since the AR means IF was redirected: drop it.
        if (hit) begin
          pulse   = 1'b1;
          state_n = S_IDLE;
        end else if (bus.inst_req_i) begin
          load_addr = 1'b1;
          state_n   = S_AR;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      addr_q <= 64'd0;
      inst_q <= NOP_INST;
      err_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (load_addr) addr_q <= bus.inst_addr_i;
      if (load_data) begin
        err_q <= bad;
        if (bad)
          inst_q <= NOP_INST;
        else if (addr_q[2])
          inst_q <= bus.r_data_i[63:32];
        else
          inst_q <= bus.r_data_i[31:0];
      end
    end
  end

  assign bus.ar_valid_o   = state == S_AR;
  assign bus.ar_addr_o    = {addr_q[63:3], 3'b000};
  assign bus.ar_id_o      = AXI_ID;
  assign bus.ar_len_o     = 8'd0;
  assign bus.ar_size_o    = 3'b011;
  assign bus.ar_burst_o   = 2'b01;
  assign bus.r_ready_o    = state == S_R;
  assign bus.inst_o       = inst_q;
  assign bus.inst_ready_o = pulse;
  assign bus.inst_err_o   = pulse & err_q;

endmodule

// File: tb/tb_ysyx_210184_if_axi_rd.sv
// Bench for the fetch responder: directed plan steps plus random
// fetches against a memory/response model and latency arithmetic.
module tb_ysyx_210184_if_axi_rd;
  localparam logic [3:0]  ID  = 4'd0;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_210184_if_axi_rd_if bus ();

  ysyx_210184_if_axi_rd #(
    .AXI_ID  (ID),
    .NOP_INST(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem64(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h1111_2222_3333_4444;
    return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
  endfunction

  function automatic logic [31:0] ref_inst(input logic [63:0] a,
                                           input logic [1:0] resp);
    logic [63:0] w;
    w = mem64({a[63:3], 3'b000});
    if (resp != 2'b00) return NOP;
    return a[2] ? w[63:32] : w[31:0];
  endfunction

  task automatic quiet();
    bus.inst_req_i  = 1'b0;
    bus.ar_ready_i  = 1'b0;
    bus.r_valid_i   = 1'b0;
    bus.r_data_i    = 64'd0;
    bus.r_resp_i    = 2'b00;
    bus.r_last_i    = 1'b0;
    bus.r_id_i      = ID;
  endtask

  // Acts as the AXI slave with the given delays; optionally redirects
  // the PC once the read data phase starts.
  task automatic fetch(input string tag,
                       input logic [63:0] a,
                       input int ard,
                       input int rd,
                       input logic [1:0] resp,
                       input bit redir,
                       input logic [63:0] b,
                       input int exp_cyc);
    logic [63:0] cur, ar_q, prev_addr;
    int ar_cnt, r_cnt, ar_hs, c;
    bit got, prev_wait, redone;
    @(negedge clk);
    bus.inst_req_i  = 1'b1;
    bus.inst_addr_i = a;
    cur = a; ar_q = '0; prev_addr = '0;
    ar_cnt = 0; r_cnt = 0; ar_hs = 0; c = 0;
    got = 0; prev_wait = 0; redone = 0;
    while (!got && c < 80) begin
      @(negedge clk);
      c++;
      bus.ar_ready_i = 1'b0;
      bus.r_valid_i  = 1'b0;
      bus.r_id_i     = ID;
      bus.r_last_i   = 1'b0;
      if (prev_wait) begin
        chk({tag, "/ar_hold"}, 64'(bus.ar_valid_o), 64'd1);
        chk({tag, "/ar_stable"}, bus.ar_addr_o, prev_addr);
      end
      if (bus.ar_valid_o) begin
        chk({tag, "/ar_fields"},
            64'({bus.ar_id_o, bus.ar_len_o,
                 bus.ar_size_o, bus.ar_burst_o}),
            64'({ID, 8'd0, 3'b011, 2'b01}));
        prev_addr = bus.ar_addr_o;
        if (ar_cnt == ard) begin
          bus.ar_ready_i = 1'b1;
          ar_q = bus.ar_addr_o;
          ar_hs++;
          ar_cnt = 0;
          r_cnt = 0;
          prev_wait = 0;
        end else begin
          ar_cnt++;
          prev_wait = 1;
        end
      end else begin
        prev_wait = 0;
      end
      if (bus.r_ready_o) begin
        if (redir && !redone) begin
          bus.inst_addr_i = b;
          cur = b;
          redone = 1;
        end
        bus.r_last_i = 1'b1;
        if (r_cnt == rd) begin
          bus.r_valid_i = 1'b1;
          bus.r_data_i  = mem64(ar_q);
          bus.r_resp_i  = resp;
        end else begin
          bus.r_valid_i = 1'($urandom_range(0, 1));
          bus.r_id_i    = ID ^ 4'h5;
          bus.r_data_i  = {$urandom, $urandom};
          bus.r_resp_i  = 2'b00;
          r_cnt++;
        end
      end
      #1;
      if (bus.inst_ready_o) got = 1;
    end
    chk({tag, "/pulse"}, 64'(got), 64'd1);
    if (exp_cyc > 0) chk({tag, "/latency"}, 64'(c), 64'(exp_cyc));
    chk({tag, "/inst"}, 64'(bus.inst_o), 64'(ref_inst(cur, resp)));
    chk({tag, "/err"}, 64'(bus.inst_err_o), 64'(resp != 2'b00));
    chk({tag, "/ar_count"}, 64'(ar_hs), redir ? 64'd2 : 64'd1);
    chk({tag, "/ar_addr"}, ar_q, {cur[63:3], 3'b000});
    @(negedge clk);
    quiet();
    #1;
    chk({tag, "/single_pulse"},
        64'({bus.inst_ready_o, bus.inst_err_o}), 64'd0);
    chk({tag, "/inst_hold"}, 64'(bus.inst_o), 64'(ref_inst(cur, resp)));
    @(negedge clk);
    #1;
    chk({tag, "/idle"}, 64'({bus.ar_valid_o, bus.r_ready_o}), 64'd0);
  endtask

  initial begin
    logic [63:0] ra;
    logic [1:0] rr;
    int ard, rd, n;
    rst = 1'b1;
    quiet();
    bus.inst_addr_i = 64'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset/valids",
        64'({bus.ar_valid_o, bus.r_ready_o,
             bus.inst_ready_o, bus.inst_err_o}), 64'd0);
    chk("reset/inst", 64'(bus.inst_o), 64'(NOP));
    chk("reset/ar_addr", bus.ar_addr_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    fetch("aligned", 64'h8000_0000, 0, 0, 2'b00, 0, 64'd0, 3);
    fetch("upper", 64'h8000_0004, 0, 0, 2'b00, 0, 64'd0, 3);
    fetch("backpressure", 64'h8000_0000, 5, 4, 2'b00, 0, 64'd0, 12);
    fetch("redirect", 64'h8000_0000, 1, 2, 2'b00, 1,
          64'h8000_0100, -1);
    fetch("error", 64'h8000_0010, 0, 0, 2'b10, 0, 64'd0, 3);

    // Reset while the data phase is open.
    @(negedge clk);
    bus.inst_req_i  = 1'b1;
    bus.inst_addr_i = 64'h8000_0040;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      bus.ar_ready_i = bus.ar_valid_o;
    end while (!bus.r_ready_o && n < 20);
    bus.ar_ready_i = 1'b0;
    chk("rst/reach_r", 64'(bus.r_ready_o), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst/async_valids",
        64'({bus.ar_valid_o, bus.r_ready_o,
             bus.inst_ready_o, bus.inst_err_o}), 64'd0);
    chk("rst/async_inst", 64'(bus.inst_o), 64'(NOP));
    @(negedge clk);
    bus.inst_req_i = 1'b0;
    bus.r_valid_i  = 1'b1;
    bus.r_id_i     = ID;
    bus.r_last_i   = 1'b1;
    bus.r_data_i   = 64'hDEAD_BEEF_CAFE_F00D;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.r_valid_i = 1'b0;
    #1;
    chk("rst/stray_beat",
        64'({bus.ar_valid_o, bus.r_ready_o,
             bus.inst_ready_o}), 64'd0);
    chk("rst/inst_kept", 64'(bus.inst_o), 64'(NOP));
    fetch("after_rst", 64'h8000_0044, 0, 0, 2'b00, 0, 64'd0, 3);

    for (int i = 0; i < 10; i++) begin
      ra  = 64'h8000_0000 + 64'($urandom_range(0, 4095)) * 64'd4;
      ard = $urandom_range(0, 3);
      rd  = $urandom_range(0, 3);
      rr  = ($urandom_range(0, 3) == 0) ?
            2'($urandom_range(1, 3)) : 2'b00;
      fetch("random", ra, ard, rd, rr, 0, 64'd0, 3 + ard + rd);
    end
    for (int i = 0; i < 3; i++) begin
      ra = 64'h8000_2000 + 64'($urandom_range(0, 255)) * 64'd4;
      fetch("rand_redir", ra, $urandom_range(0, 2),
            $urandom_range(0, 2), 2'b00, 1,
            ra + 64'h400, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ysyx_210184_if_axi_rd.md
# ysyx_210184_if_axi_rd

Instruction-fetch bus responder: accepts the fetch address driven by the IF stage, performs a single-beat AXI4 read on the instruction port, and returns the selected 32-bit instruction together with a one-cycle `inst_ready_o` pulse. IF consumes this pulse as `MAC_ready` and injects a bubble (`0x00000013`) whenever it is low. The block sits between the IF stage and the core's AXI crossbar read channel.

## Interface
- `AXI_ID`, default 4'd0: value driven on `ar_id_o`; `r_id_i` must match for a beat to be consumed.
- `NOP_INST`, default 32'h0000_0013: instruction returned on a bus error.

- `clk`  in  1  core clock
- `rst`  in  1  reset, asynchronous, active-high
- `inst_addr_i`  in  64  fetch PC from IF; byte address, `[1:0]` ignored
- `inst_req_i`  in  1  fetch request; IF holds it high while it wants an instruction
- `inst_o`  out  32  fetched instruction; valid when `inst_ready_o`=1
- `inst_ready_o`  out  1  one-cycle pulse, instruction for the current `inst_addr_i` is on `inst_o`
- `inst_err_o`  out  1  one-cycle pulse alongside `inst_ready_o` when the response is non-OKAY
- `ar_valid_o`, `ar_ready_i`  out/in  1  AXI AR handshake
- `ar_addr_o`  out  64  `{addr_q[63:3],3'b000}`
- `ar_id_o`  out  4  `AXI_ID`
- `ar_len_o`  out  8  constant 0
- `ar_size_o`  out  3  constant 3'b011
- `ar_burst_o`  out  2  constant 2'b01
- `r_valid_i`, `r_ready_o`  in/out  1  AXI R handshake
- `r_data_i`  in  64  read data
- `r_resp_i`  in  2  read response
- `r_last_i`  in  1  last beat
- `r_id_i`  in  4  response ID

## Operation
- States: IDLE, AR, R, RESP.
- IDLE: if `inst_req_i`=1, latch `inst_addr_i` into `addr_q` and go to AR.
- AR: `ar_valid_o`=1. `ar_addr_o`, `ar_id_o`, `ar_len_o`, `ar_size_o` and `ar_burst_o` are stable until `ar_ready_i`=1, then go to R.
- R: `r_ready_o`=1. A beat is consumed only when `r_valid_i`=1 and `r_id_i`=`AXI_ID`.
  - On the consumed beat with `r_last_i`=1, register the data: `inst_o` = `addr_q[2]` ? `r_data_i[63:32]` : `r_data_i[31:0]`. If `r_resp_i`≠2'b00, register `NOP_INST` instead and set the error flag.
  - Then go to RESP.
- RESP: if `inst_addr_i`==`addr_q` and `inst_req_i`=1, pulse `inst_ready_o` (and `inst_err_o` if the flag is set), then go to IDLE.
  - Otherwise the result is stale because IF was flushed or redirected. Do not pulse. If `inst_req_i`=1, re-latch `inst_addr_i` and go to AR; else go to IDLE.
- A redirect of `inst_addr_i` during AR or R does not abort the transaction; AXI handshakes always complete. Staleness is resolved in RESP.
- `inst_o` holds its last value between pulses.

## Timing
- Reset values: state IDLE, `inst_o`=`NOP_INST`, `addr_q`=0, all `*_valid_o`/`r_ready_o`/`inst_ready_o`/`inst_err_o`=0.
- Reset asserted mid-transaction: return to IDLE immediately and drop `ar_valid_o`/`r_ready_o`. Any in-flight R beat after reset is ignored.
- Minimum latency, with `ar_ready_i` and `r_valid_i` both 1 on first opportunity:
  - cycle 0: request sampled in IDLE
  - cycle 1: AR
  - cycle 2: R
  - cycle 3: RESP with `inst_ready_o`=1
  - Next request is sampled at cycle 4 at the earliest.
- `ar_valid_o` never deasserts before `ar_ready_i` (except on reset).
- `r_ready_o` is 1 only in R.
- `inst_ready_o` and `inst_err_o` are never high for two consecutive cycles.
- Only one outstanding AR at any time.

## Test plan
- Aligned fetch: `inst_addr_i`=0x8000_0000, `ar_ready_i`=1, R beat `r_data_i`=0x1111_2222_3333_4444, OKAY -> `ar_addr_o`=0x8000_0000, `inst_o`=0x3333_4444, `inst_ready_o` pulses at cycle 3.
- Upper word: `inst_addr_i`=0x8000_0004, same data -> `ar_addr_o`=0x8000_0000, `inst_o`=0x1111_2222.
- Backpressure: `ar_ready_i` low for 5 cycles and `r_valid_i` delayed 4 cycles -> `ar_valid_o` and address stay stable; exactly one `inst_ready_o` pulse at cycle 12.
- Redirect: `inst_addr_i` changes from 0x8000_0000 to 0x8000_0100 during R -> no pulse for the old address; a second AR is issued with 0x8000_0100 and a single pulse carries the new data.
- Error: `r_resp_i`=2'b10 -> `inst_o`=0x0000_0013, `inst_ready_o` and `inst_err_o` pulse together.
- Reset in R: assert `rst` while `r_ready_o`=1 -> all outputs go to their reset values asynchronously; after release the block is IDLE and the next request issues a fresh AR.
